// File: rtl/cnn_pkg.sv
// Shared CNN definitions: padded edge length helper, crop FSM states, default element width.
package cnn_pkg;

    localparam int DEF_DATA_W = 32;

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} crop_state_t;

    // Padding and cropping stages must agree on this value.
    function automatic int pad_size(input int size, input int filter);
        return size + ((filter - (size % filter)) % filter);
    endfunction

endpackage

// File: rtl/output_crop_raster_counter.sv
// Row/column raster position counter over an EDGE x EDGE map.
module raster_counter #(
    parameter int EDGE = 9,
    parameter int W    = (EDGE > 1) ? $clog2(EDGE) : 1
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         inc,
    input  logic         clr,
    output logic [W-1:0] row,
    output logic [W-1:0] col,
    output logic         wrap_last
);
    localparam logic [W-1:0] LAST = W'(EDGE - 1);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            row <= '0;
            col <= '0;
        end else if (clr) begin
            row <= '0;
            col <= '0;
        end else if (inc) begin
            if (col == LAST) begin
                col <= '0;
                row <= (row == LAST) ? '0 : row + 1'b1;
            end else begin
                col <= col + 1'b1;
            end
        end
    end

    assign wrap_last = (row == LAST) && (col == LAST);

endmodule

// File: rtl/output_crop.sv
// Streaming crop of a PAD_SIZE x PAD_SIZE raster back to SIZE x SIZE.
// Optional nonzero-pad detection enabled by defining CROP_PAD_CHECK_EN.
module output_crop
    import cnn_pkg::*;
#(
    parameter int SIZE        = 7,
    parameter int FILTER_SIZE = 3,
    parameter int DATA_W      = DEF_DATA_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              en,
    input  logic              start,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_last,
    output logic              busy,
    output logic              done,
    output logic              pad_err
);
    localparam int PAD_SIZE = pad_size(SIZE, FILTER_SIZE);
    localparam int CW       = (PAD_SIZE > 1) ? $clog2(PAD_SIZE) : 1;

    crop_state_t   state, state_nx;
    logic [CW-1:0] row, col;
    logic          wrap_last;
    logic          is_pad, keep_last, acc, keep, consume, start_go, drain_exit;

    raster_counter #(.EDGE(PAD_SIZE), .W(CW)) u_cnt (
        .clk       (clk),
        .reset     (reset),
        .inc       (acc),
        .clr       (start_go),
        .row       (row),
        .col       (col),
        .wrap_last (wrap_last)
    );

    // Extra MSB so SIZE is representable even when PAD_SIZE == SIZE is a power of two.
    assign is_pad    = ({1'b0, row} >= (CW+1)'(SIZE)) || ({1'b0, col} >= (CW+1)'(SIZE));
    assign keep_last = ({1'b0, row} == (CW+1)'(SIZE - 1)) && ({1'b0, col} == (CW+1)'(SIZE - 1));

    assign in_ready   = en && (state == RUN) && (is_pad || !out_valid || out_ready);
    assign acc        = in_valid && in_ready;
    assign keep       = acc && !is_pad;
    assign consume    = en && out_valid && out_ready;
    assign start_go   = en && start && (state == IDLE);
    assign drain_exit = en && (state == DRAIN) && (!out_valid || out_ready);
    assign busy       = (state == RUN) || (state == DRAIN);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (start_go) state_nx = RUN;
            RUN:     if (acc && wrap_last) state_nx = DRAIN;
            DRAIN:   if (drain_exit) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_last  <= 1'b0;
        end else if (keep) begin
            out_valid <= 1'b1;
            out_data  <= in_data;
            out_last  <= keep_last;
        end else if (consume) begin
            out_valid <= 1'b0;
            out_last  <= 1'b0;
        end
    end

    // done is a pulse: it never stretches, even if en drops right after the drain.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) done <= 1'b0;
        else       done <= drain_exit;
    end

`ifdef CROP_PAD_CHECK_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            pad_err <= 1'b0;
        else if (start_go)
            pad_err <= 1'b0;
        else if (acc && is_pad && (in_data != '0))
            pad_err <= 1'b1;
    end
`else
    assign pad_err = 1'b0;
`endif

endmodule

// File: tb/tb_output_crop.sv
// Directed bench for output_crop: table of 7/3 frame scenarios plus a 6/3 pass-through frame.
module tb_output_crop;
    localparam int N7 = 9 * 9;
    localparam int N6 = 6 * 6;
`ifdef CROP_PAD_CHECK_EN
    localparam bit PCHK = 1'b1;
`else
    localparam bit PCHK = 1'b0;
`endif

    logic        clk = 0, reset, en, start, in_valid, out_ready;
    logic [31:0] in_data;
    logic        in_ready, out_valid, out_last, busy, done, pad_err;
    logic [31:0] out_data;
    logic        start6, in_valid6;
    logic        in_ready6, out_valid6, out_last6, busy6, done6, pad_err6;
    logic [31:0] out_data6;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    output_crop #(.SIZE(7), .FILTER_SIZE(3), .DATA_W(32)) dut (
        .clk(clk), .reset(reset), .en(en), .start(start),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_last(out_last), .busy(busy), .done(done), .pad_err(pad_err)
    );

    output_crop #(.SIZE(6), .FILTER_SIZE(3), .DATA_W(32)) dut6 (
        .clk(clk), .reset(reset), .en(en), .start(start6),
        .in_valid(in_valid6), .in_ready(in_ready6), .in_data(in_data),
        .out_valid(out_valid6), .out_ready(out_ready), .out_data(out_data6),
        .out_last(out_last6), .busy(busy6), .done(done6), .pad_err(pad_err6)
    );

    typedef struct {
        bit tog;       // out_ready toggles every cycle
        bit gap;       // in_valid randomly dropped
        int stall_at;  // en low for 5 cycles once this many accepts are done (-1 off)
        int rst_at;    // reset after this many accepts (-1 off)
        bit bad_pad;   // drive 5 on pad element (row 0, col 8)
        int exp_n;     // expected output count
        int exp_last;  // expected data carrying out_last
    } vec_t;

    vec_t vecs[7];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    // k-th kept value when padded inputs are numbered 0..p*p-1
    function automatic int exp_val(input int k, input int s, input int p);
        return (k / s) * p + (k % s);
    endfunction

    function automatic bit is_pad7(input int n);
        return ((n / 9) >= 7) || ((n % 9) >= 7);
    endfunction

    task automatic run_frame(input vec_t v);
        int nin = 0, nout = 0, cyc = 0, stall = 0, hold = 0;
        bit saw_done = 0, pe_pending = 0;
        @(negedge clk);
        start = 1; in_valid = 0; en = 1; out_ready = 1;
        @(negedge clk);
        start = 0;
        #1;
        chk("busy_after_start", busy, 1);
        chk("pad_err_cleared_on_start", pad_err, 0);
        while (!saw_done && cyc < 3000) begin
            if (v.rst_at >= 0 && nin == v.rst_at) begin
                reset = 1; in_valid = 0;
                #1;
                chk("rst_out_valid", out_valid, 0);
                chk("rst_busy", busy, 0);
                chk("rst_done", done, 0);
                chk("rst_in_ready", in_ready, 0);
                @(negedge clk);
                reset = 0;
                return;
            end
            en = !(v.stall_at >= 0 && nin == v.stall_at && stall < 5);
            if (!en && stall == 0) begin
                hold = nin - 1;
                while (is_pad7(hold)) hold--;
            end
            in_valid  = (nin < N7) && !(v.gap && $urandom_range(0, 2) == 0);
            in_data   = (v.bad_pad && nin == 8) ? 32'd5 : 32'(nin);
            out_ready = v.tog ? cyc[0] : 1'b1;
            #1;
            if (pe_pending) begin
                chk("pad_err_set", pad_err, 32'(PCHK));
                pe_pending = 0;
            end
            if (!en) begin
                chk("stall_in_ready", in_ready, 0);
                chk("stall_out_valid", out_valid, 1);
                chk("stall_out_data", out_data, 32'(hold));
                stall++;
            end else if (nin < N7 && is_pad7(nin)) begin
                chk("pad_in_ready", in_ready, 1);
            end
            if (en && out_valid && out_ready) begin
                chk("out_data", out_data, 32'(exp_val(nout, 7, 9)));
                chk("out_last", out_last, 32'(nout == v.exp_n - 1));
                nout++;
            end
            if (in_valid && in_ready) begin
                if (v.bad_pad && nin == 8) pe_pending = 1;
                nin++;
            end
            if (done) begin
                saw_done = 1;
                chk("busy_low_with_done", busy, 0);
            end
            cyc++;
            @(negedge clk);
        end
        chk("frame_done_seen", 32'(saw_done), 1);
        chk("out_count", 32'(nout), 32'(v.exp_n));
        chk("last_value", 32'(exp_val(nout - 1, 7, 9)), 32'(v.exp_last));
        chk("pad_err_at_end", pad_err, 32'(PCHK && v.bad_pad));
        #1;
        chk("done_one_cycle", done, 0);
    endtask

    task automatic run_frame6();
        int nin = 0, nout = 0, cyc = 0;
        bit saw_done = 0;
        @(negedge clk);
        start6 = 1; in_valid6 = 0; en = 1; out_ready = 1;
        @(negedge clk);
        start6 = 0;
        while (!saw_done && cyc < 500) begin
            in_valid6 = (nin < N6);
            in_data   = 32'(nin);
            #1;
            if (out_valid6 && out_ready) begin
                chk("p6_out_data", out_data6, 32'(nout));
                chk("p6_out_last", out_last6, 32'(nout == N6 - 1));
                nout++;
            end
            if (in_valid6 && in_ready6) nin++;
            if (done6) saw_done = 1;
            cyc++;
            @(negedge clk);
        end
        in_valid6 = 0;
        chk("p6_done_seen", 32'(saw_done), 1);
        chk("p6_out_count", 32'(nout), 32'(N6));
        chk("p6_pad_err", pad_err6, 0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1; en = 0; start = 0; in_valid = 0; out_ready = 0; in_data = '0;
        start6 = 0; in_valid6 = 0;
        vecs[0] = '{tog:0, gap:0, stall_at:-1, rst_at:-1, bad_pad:0, exp_n:49, exp_last:60};
        vecs[1] = '{tog:1, gap:1, stall_at:-1, rst_at:-1, bad_pad:0, exp_n:49, exp_last:60};
        vecs[2] = '{tog:0, gap:0, stall_at:20, rst_at:-1, bad_pad:0, exp_n:49, exp_last:60};
        vecs[3] = '{tog:0, gap:0, stall_at:-1, rst_at:30, bad_pad:0, exp_n:0,  exp_last:0};
        vecs[4] = '{tog:0, gap:0, stall_at:-1, rst_at:-1, bad_pad:0, exp_n:49, exp_last:60};
        vecs[5] = '{tog:0, gap:0, stall_at:-1, rst_at:-1, bad_pad:1, exp_n:49, exp_last:60};
        vecs[6] = '{tog:1, gap:0, stall_at:-1, rst_at:-1, bad_pad:0, exp_n:49, exp_last:60};
        repeat (3) @(negedge clk);
        #1;
        chk("reset_out_valid", out_valid, 0);
        chk("reset_out_data", out_data, 0);
        chk("reset_out_last", out_last, 0);
        chk("reset_busy", busy, 0);
        chk("reset_done", done, 0);
        chk("reset_pad_err", pad_err, 0);
        chk("reset_in_ready", in_ready, 0);
        @(negedge clk);
        reset = 0;
        en = 1;
        @(negedge clk);
        #1;
        chk("idle_in_ready", in_ready, 0);
        for (int i = 0; i < 7; i++) run_frame(vecs[i]);
        run_frame6();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/output_crop.md
Name: output_crop

Overview:
- Streaming inverse of the input padding stage. Consumes a PAD_SIZE x PAD_SIZE feature map in raster order, discards the trailing zero-pad rows and columns, and emits the original SIZE x SIZE map in raster order.
- Sits after the convolution/pooling datapath. Returns frames to their native size before writeback.
- Valid/ready handshake on both sides, with a single output register stage.

Parameters:
- SIZE, 7, native map edge length (elements)
- FILTER_SIZE, 3, filter edge used by the padding stage
- DATA_W, 32, element width in bits
- PAD_SIZE (localparam), SIZE+((FILTER_SIZE-(SIZE%FILTER_SIZE))%FILTER_SIZE), padded edge length (9 for defaults)

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-high reset
- en  in  1  global enable; low freezes all state
- start  in  1  one-cycle pulse; begins a frame when IDLE
- in_valid  in  1  padded element present
- in_ready  out  1  element accepted when in_valid&&in_ready
- in_data  in  DATA_W  padded element
- out_valid  out  1  cropped element present
- out_ready  in  1  downstream accepts
- out_data  out  DATA_W  cropped element
- out_last  out  1  marks element (SIZE-1,SIZE-1)
- busy  out  1  high in RUN or DRAIN
- done  out  1  one-cycle pulse at frame end
- pad_err  out  1  sticky nonzero-pad flag (see Optional Feature)

Behaviour:
- Reset (async, any time, including mid-frame): state=IDLE, row=col=0, out_valid=0, out_data=0, out_last=0, done=0, pad_err=0.
- FSM IDLE -> RUN:
  - Transition on start&&en.
  - Clear row/col on entry.
  - start is ignored outside IDLE.
- RUN:
  - is_pad = (row>=SIZE)||(col>=SIZE), decoded from the counters before the accept.
  - in_ready = en && (is_pad || !out_valid || out_ready).
  - Pad elements are accepted and dropped without touching the output register.
  - Kept element: out_data<=in_data, out_valid<=1 next cycle, out_last<=(row==SIZE-1 && col==SIZE-1). Latency 1 cycle input to output.
- Output register:
  - out_valid clears on out_valid&&out_ready&&en when no new kept element arrives that cycle.
  - A simultaneous consume and kept accept keeps out_valid=1 with the new data, so throughput is 1 element/cycle.
- Counters, advanced on accept:
  - col increments, wrapping at PAD_SIZE-1 to 0.
  - row increments on col wrap.
  - Widths: $clog2(PAD_SIZE), minimum 1.
- RUN -> DRAIN on accept of (PAD_SIZE-1,PAD_SIZE-1).
- DRAIN:
  - in_ready=0.
  - Wait until out_valid==0, or it is being consumed this cycle.
  - Then done=1 for one cycle and return to IDLE.
- en=0: no state, counter or register changes. in_ready=0. out_valid and out_data held stable; the consume is not taken.
- PAD_SIZE==SIZE (SIZE%FILTER_SIZE==0): pure pass-through. out_last is on the final input.
- out_last and out_data hold until consumed. Only one element has out_last=1 per frame.

Optional Feature:
- Macro CROP_PAD_CHECK_EN.
- Defined: any accepted pad element with in_data!=0 sets pad_err. pad_err clears only on reset or on start in IDLE.
- Undefined: pad_err is tied to 0, and no compare logic is present.

Decomposition:
- Shared package cnn_pkg holds:
  - function pad_size(size, filter), shared with the padding stage so both sides agree on PAD_SIZE
  - state typedef crop_state_t {IDLE, RUN, DRAIN}
  - default DATA_W
- One sub-module, raster_counter. Parameterised by edge length. Outputs row/col, with inc, clr and wrap_last.

Test Plan:
- SIZE=7, FILTER=3: start, stream in_data=0..80 with in_valid=1 and out_ready=1.
  - Exactly 49 outputs: 0..6, 9..15, ..., 54..60.
  - out_last with data 60. done 1 cycle after the drain. busy falls with done.
- Same frame with out_ready toggling 1010..., and in_valid randomly gapped.
  - Identical 49-value sequence; no duplicates or drops.
  - in_ready stays high on pad elements (cols 7,8; rows 7,8) even while out_valid=1 and out_ready=0.
- SIZE=6, FILTER=3 (PAD_SIZE=6): stream 0..35.
  - Output is all 36 values unchanged. out_last on 35.
- Assert reset after 30 accepts in the 7/3 frame.
  - out_valid, busy and done go to 0 immediately. in_ready=0.
  - A fresh start then yields the correct 49-value frame.
- en=0 for 5 cycles mid-frame while out_valid=1.
  - out_data and out_valid held. in_ready=0. Counters unchanged. Stream resumes correctly.
- With CROP_PAD_CHECK_EN defined: send in_data=5 at (row 0, col 8).
  - pad_err=1 from the next cycle and stays high through done.
  - pad_err clears on the next start.
  - Without the macro, pad_err stays 0.
